dmem_lsu: RTL

Parametrised data memory for the single-cycle/multi-cycle RISC-V datapath. Replaces the word-only, combinational-read memory with a request/response port. Supports byte, halfword and word loads and stores, with sign or zero extension, and a configurable access latency. Misaligned and out-of-range accesses are flagged and have no side effects. Sits between the execute stage and the writeback mux.

---
 rtl/dmem_lsu.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Request/response data memory for the RISC-V datapath: byte/half/word loads and stores with
// configurable latency and error flagging. Optional macro DMEM_CLEAR_ON_RESET_EN zeroes memory after reset.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  // Handshake: a request is taken on a rising edge where req_valid && req_ready; req_ready is
  // high only in IDLE outside reset, and rsp_valid pulses for the single cycle spent in RESP.
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          a_we, a_uns;
  logic [1:0]    a_size;
  logic [31:0]   a_addr, a_wdata;
  logic [AW-1:0] a_idx;
  logic          a_misaligned, a_oor, a_err;
  logic [31:0]   rd_word, rd_shift, load_data;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          clr_we;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With LATENCY=1 the access happens on the accepting edge, so use the live request fields.
  assign a_we    = (state_q == S_IDLE) ? req_we       : we_q;
  assign a_size  = (state_q == S_IDLE) ? req_size     : size_q;
  assign a_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;
  assign a_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
  assign a_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;
  assign a_idx   = a_addr[AW+1:2];

  always_comb begin
    a_misaligned = 1'b0;
    case (a_size)
      2'b00:   a_misaligned = 1'b0;
      2'b01:   a_misaligned = a_addr[0];
      2'b10:   a_misaligned = (a_addr[1:0] != 2'b00);
      default: a_misaligned = 1'b1;
    endcase
  end

  assign a_oor = |a_addr[31:AW+2];
  assign a_err = a_misaligned || a_oor;

  assign rd_word  = mem_q[a_idx];
  assign rd_shift = rd_word >> {a_addr[1:0], 3'b000};

  always_comb begin
    load_data = rd_word;
    case (a_size)
      2'b00:   load_data = a_uns ? {24'b0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = a_uns ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = a_wdata;
    case (a_size)
      2'b00: begin
        st_be   = 4'b0001 << a_addr[1:0];
        st_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = a_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{a_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = a_wdata;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_RESP: state_d = S_IDLE;
      default: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(DEPTH_WORDS - 1)) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
    endcase
  end

  assign enter_resp  = (state_d == S_RESP) && (state_q != S_RESP) && !rst;
  assign rsp_valid_d = enter_resp;
  assign rsp_err_d   = enter_resp && a_err;
  assign rsp_rdata_d = (enter_resp && !a_we && !a_err) ? load_data : 32'd0;

`ifdef DMEM_CLEAR_ON_RESET_EN
  assign clr_we = (state_q == S_CLEAR) && !rst;
`else
  assign clr_we = 1'b0;
`endif

  // Single write port shared by the clear sweep and stores; they never overlap in time.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = a_idx;
    wr_be   = st_be;
    wr_data = st_data;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx_q;
      wr_be   = 4'b1111;
      wr_data = 32'd0;
    end else if (enter_resp && a_we && !a_err) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      clr_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      clr_idx_q   <= clr_idx_d;
    end
  end

endmodule
